// File: rtl/tow_pkg.sv
// Shared types, constants and position helpers for the tug-of-war game.
package tow_pkg;

   typedef enum logic [3:0] {
      POS_L3, POS_L2, POS_L1, POS_N, POS_R1, POS_R2, POS_R3, POS_LWIN, POS_RWIN
   } pos_t;

   typedef enum logic {PH_DARK, PH_PLAY} phase_t;

   localparam int         DARK_BASE    = 256;
   localparam int         PLAY_TIMEOUT = 512;
   localparam int         BLINK        = 128;
   localparam logic [7:0] LFSR_SEED    = 8'h01;

   localparam logic [6:0] LED_OFF  = 7'b0000000;
   localparam logic [6:0] LED_L3   = 7'b1000000;
   localparam logic [6:0] LED_L2   = 7'b0100000;
   localparam logic [6:0] LED_L1   = 7'b0010000;
   localparam logic [6:0] LED_N    = 7'b0001000;
   localparam logic [6:0] LED_R1   = 7'b0000100;
   localparam logic [6:0] LED_R2   = 7'b0000010;
   localparam logic [6:0] LED_R3   = 7'b0000001;
   localparam logic [6:0] LED_LWIN = 7'b1110000;
   localparam logic [6:0] LED_RWIN = 7'b0000111;

   // For WIN positions this is the "on" half of the blink pattern.
   function automatic logic [6:0] pos_led(input pos_t p);
      case (p)
         POS_L3:   pos_led = LED_L3;
         POS_L2:   pos_led = LED_L2;
         POS_L1:   pos_led = LED_L1;
         POS_N:    pos_led = LED_N;
         POS_R1:   pos_led = LED_R1;
         POS_R2:   pos_led = LED_R2;
         POS_R3:   pos_led = LED_R3;
         POS_LWIN: pos_led = LED_LWIN;
         POS_RWIN: pos_led = LED_RWIN;
         default:  pos_led = LED_OFF;
      endcase
   endfunction

   function automatic logic is_win(input pos_t p);
      return (p == POS_LWIN) || (p == POS_RWIN);
   endfunction

   function automatic pos_t step_right(input pos_t p);
      case (p)
         POS_L3:  step_right = POS_L2;
         POS_L2:  step_right = POS_L1;
         POS_L1:  step_right = POS_N;
         POS_N:   step_right = POS_R1;
         POS_R1:  step_right = POS_R2;
         POS_R2:  step_right = POS_R3;
         POS_R3:  step_right = POS_RWIN;
         default: step_right = p;
      endcase
   endfunction

   function automatic pos_t step_left(input pos_t p);
      case (p)
         POS_R3:  step_left = POS_R2;
         POS_R2:  step_left = POS_R1;
         POS_R1:  step_left = POS_N;
         POS_N:   step_left = POS_L1;
         POS_L1:  step_left = POS_L2;
         POS_L2:  step_left = POS_L3;
         POS_L3:  step_left = POS_LWIN;
         default: step_left = p;
      endcase
   endfunction

   // A pusher on the opponent's side recovers two steps at once.
   function automatic pos_t play_move(input pos_t p, input logic right);
      if (right)
         play_move = (p == POS_L3 || p == POS_L2 || p == POS_L1) ? step_right(step_right(p)) : step_right(p);
      else
         play_move = (p == POS_R3 || p == POS_R2 || p == POS_R1) ? step_left(step_left(p)) : step_left(p);
   endfunction

   function automatic pos_t jump_move(input pos_t p, input logic right);
      jump_move = right ? step_left(p) : step_right(p);
   endfunction

endpackage

// File: rtl/tow_lfsr.sv
// Free-running 8-bit maximal-length LFSR (x^8+x^6+x^5+x^4+1) used to randomise DARK length.
module tow_lfsr
   import tow_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= LFSR_SEED;
      else
         q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   end

endmodule

// File: rtl/tow.sv
// Tug-of-war game: button synchronisers, DARK/PLAY round control, rope position and blinking win display.
module tow
   import tow_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       pbr,
   input  logic       pbl,
   output logic [6:0] Led
);

   logic [7:0] lfsr_q;
   logic [2:0] pbr_sync;
   logic [2:0] pbl_sync;
   logic       push_r;
   logic       push_l;
   pos_t       pos;
   pos_t       next_pos;
   phase_t     phase;
   logic [8:0] cnt;
   logic [8:0] dark_end;
   logic [8:0] dark_end_new;
   logic       restart;

   tow_lfsr u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   // Bits [1:0] are the two synchroniser stages; bit [2] holds the previous synced value for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pbr_sync <= 3'b000;
         pbl_sync <= 3'b000;
      end else begin
         pbr_sync <= {pbr_sync[1:0], pbr};
         pbl_sync <= {pbl_sync[1:0], pbl};
      end
   end

   assign push_r       = pbr_sync[1] & ~pbr_sync[2];
   assign push_l       = pbl_sync[1] & ~pbl_sync[2];
   assign dark_end_new = 9'(DARK_BASE - 1) + {1'b0, lfsr_q};

   always_comb begin
      next_pos = pos;
      if (push_r && !push_l)
         next_pos = (phase == PH_PLAY) ? play_move(pos, 1'b1) : jump_move(pos, 1'b1);
      else if (push_l && !push_r)
         next_pos = (phase == PH_PLAY) ? play_move(pos, 1'b0) : jump_move(pos, 1'b0);
   end

   // Round controller: a push always ends the round, otherwise the phase counter runs out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos      <= POS_N;
         phase    <= PH_DARK;
         Led      <= LED_OFF;
         cnt      <= '0;
         dark_end <= '0;
         restart  <= 1'b1;
      end else if (restart) begin
         restart  <= 1'b0;
         cnt      <= '0;
         dark_end <= dark_end_new;
      end else if (is_win(pos)) begin
         if (cnt == 9'(BLINK - 1)) begin
            cnt <= '0;
            Led <= (Led == LED_OFF) ? pos_led(pos) : LED_OFF;
         end else begin
            cnt <= cnt + 9'd1;
         end
      end else if (push_r || push_l) begin
         pos   <= next_pos;
         phase <= PH_DARK;
         cnt   <= '0;
         if (is_win(next_pos)) begin
            Led <= pos_led(next_pos);
         end else begin
            Led      <= LED_OFF;
            dark_end <= dark_end_new;
         end
      end else if (phase == PH_DARK) begin
         if (cnt == dark_end) begin
            phase <= PH_PLAY;
            cnt   <= '0;
            Led   <= pos_led(pos);
         end else begin
            cnt <= cnt + 9'd1;
         end
      end else begin
         if (cnt == 9'(PLAY_TIMEOUT - 1)) begin
            phase    <= PH_DARK;
            cnt      <= '0;
            dark_end <= dark_end_new;
            Led      <= LED_OFF;
         end else begin
            cnt <= cnt + 9'd1;
         end
      end
   end

endmodule

// File: tb/tb_tow.sv
// Self-checking bench for tow: per-cycle comparison against an arithmetic game model plus directed literal checks.
module tb_tow;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pbr = 1'b0;
   logic       pbl = 1'b0;
   logic [6:0] Led;

   int checks   = 0;
   int failures = 0;

   // Model: position as an integer -3..+3 (right positive), -4 = LWIN, +4 = RWIN.
   int         m_pos;
   bit         m_dark;
   bit         m_first;
   int         m_timer;
   int         m_blink;
   logic [6:0] m_led;
   logic [7:0] m_lfsr;
   logic [2:0] h_r;
   logic [2:0] h_l;

   tow dut (
      .clk (clk),
      .rst (rst),
      .pbr (pbr),
      .pbl (pbl),
      .Led (Led)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [6:0] led_of(input int p);
      logic [6:0] one;
      one = 7'b0000001;
      if (p <= -4) return 7'b1110000;
      if (p >= 4) return 7'b0000111;
      return one << (3 - p);
   endfunction

   task automatic model_reset();
      m_pos   = 0;
      m_first = 1'b1;
      m_dark  = 1'b1;
      m_timer = 0;
      m_blink = 0;
      m_led   = 7'b0;
      m_lfsr  = 8'h01;
      h_r     = 3'b0;
      h_l     = 3'b0;
   endtask

   // Game rules applied at one clock edge with the button levels present at that edge.
   task automatic model_edge(input logic r, input logic l);
      bit         pr;
      bit         pl;
      logic [7:0] r_now;
      pr     = h_r[1] && !h_r[2];
      pl     = h_l[1] && !h_l[2];
      h_r    = {h_r[1:0], r};
      h_l    = {h_l[1:0], l};
      r_now  = m_lfsr;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b10111000)};
      if (m_first) begin
         m_first = 1'b0;
         m_dark  = 1'b1;
         m_timer = 256 + int'(r_now);
      end else if (m_pos == 4 || m_pos == -4) begin
         m_blink--;
         if (m_blink == 0) begin
            m_blink = 128;
            m_led   = (m_led == 7'b0) ? led_of(m_pos) : 7'b0;
         end
      end else if (pr || pl) begin
         if (pr && !pl)
            m_pos = m_dark ? m_pos - 1 : (m_pos < 0 ? m_pos + 2 : m_pos + 1);
         else if (pl && !pr)
            m_pos = m_dark ? m_pos + 1 : (m_pos > 0 ? m_pos - 2 : m_pos - 1);
         if (m_pos == 4 || m_pos == -4) begin
            m_led   = led_of(m_pos);
            m_blink = 128;
         end else begin
            m_dark  = 1'b1;
            m_timer = 256 + int'(r_now);
            m_led   = 7'b0;
         end
      end else begin
         m_timer--;
         if (m_timer == 0) begin
            if (m_dark) begin
               m_dark  = 1'b0;
               m_timer = 512;
               m_led   = led_of(m_pos);
            end else begin
               m_dark  = 1'b1;
               m_timer = 256 + int'(r_now);
               m_led   = 7'b0;
            end
         end
      end
   endtask

   // One clock cycle: drive at negedge, advance model at posedge, compare at the next negedge.
   task automatic applyStimulus(input logic r, input logic l);
      pbr = r;
      pbl = l;
      @(posedge clk);
      model_edge(r, l);
      @(negedge clk);
      checkOutput("led_vs_model", {25'b0, Led}, {25'b0, m_led});
   endtask

   task automatic do_reset();
      pbr = 1'b0;
      pbl = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      checkOutput("led_in_reset", {25'b0, Led}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_play(input string name);
      int n;
      n = 0;
      while (m_dark && n < 1200) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
      if (m_dark) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_timeout: still dark after %0d cycles", name, n);
      end
   endtask

   task automatic play_check(input string name, input logic [6:0] expected);
      wait_play(name);
      checkOutput(name, {25'b0, Led}, {25'b0, expected});
   endtask

   task automatic press(input logic r, input logic l, input int hold);
      repeat (hold) applyStimulus(r, l);
      repeat (4) applyStimulus(1'b0, 1'b0);
   endtask

   task automatic on_time(input logic r, input logic l);
      wait_play("on_time_wait");
      press(r, l, 6);
   endtask

   initial begin
      int n;
      bit r_val;
      bit l_val;
      int r_left;
      int l_left;

      rst = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      checkOutput("led_at_reset", {25'b0, Led}, 32'h0);
      rst = 1'b1;

      // First DARK samples LFSR = 1, so PLAY starts on edge 1 + 256 + 1.
      n = 0;
      while (Led == 7'b0 && n < 600) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
      checkOutput("first_dark_len", n, 258);
      checkOutput("start_N", {25'b0, Led}, 32'b0001000);

      on_time(1'b1, 1'b0); play_check("play_R1", 7'b0000100);
      on_time(1'b1, 1'b0); play_check("play_R2", 7'b0000010);
      on_time(1'b1, 1'b0); play_check("play_R3", 7'b0000001);

      // Let PLAY time out to get into DARK at R3, then jump the gun.
      n = 0;
      while (!m_dark && n < 600) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
      checkOutput("timeout_dark_R3", {25'b0, Led}, 32'h0);
      press(1'b1, 1'b0, 6);
      play_check("jump_R2", 7'b0000010);
      on_time(1'b1, 1'b0); play_check("back_R3", 7'b0000001);
      on_time(1'b0, 1'b1); play_check("left_two_R1", 7'b0000100);

      on_time(1'b1, 1'b0); play_check("again_R2", 7'b0000010);
      on_time(1'b1, 1'b0); play_check("again_R3", 7'b0000001);
      on_time(1'b1, 1'b0);
      checkOutput("rwin_on", {25'b0, Led}, 32'b0000111);
      for (int i = 0; i < 130; i++) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("rwin_off", {25'b0, Led}, 32'h0);
      for (int i = 0; i < 128; i++) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("rwin_on_again", {25'b0, Led}, 32'b0000111);
      do_reset();
      play_check("after_win_reset_N", 7'b0001000);

      on_time(1'b0, 1'b1); play_check("play_L1", 7'b0010000);
      on_time(1'b0, 1'b1); play_check("play_L2", 7'b0100000);
      on_time(1'b0, 1'b1); play_check("play_L3", 7'b1000000);
      on_time(1'b0, 1'b1);
      checkOutput("lwin_on", {25'b0, Led}, 32'b1110000);
      repeat (200) applyStimulus(1'b0, 1'b0);

      do_reset();
      wait_play("simul_wait");
      press(1'b1, 1'b1, 6);
      checkOutput("simul_dark", {25'b0, Led}, 32'h0);
      play_check("simul_N", 7'b0001000);

      repeat (511) applyStimulus(1'b0, 1'b0);
      checkOutput("timeout_last_play", {25'b0, Led}, 32'b0001000);
      applyStimulus(1'b0, 1'b0);
      checkOutput("timeout_dark", {25'b0, Led}, 32'h0);
      play_check("timeout_N", 7'b0001000);

      // Random button traffic with varying activity; each epoch begins with a reset at an arbitrary point.
      for (int e = 0; e < 6; e++) begin
         do_reset();
         r_val  = 1'b0;
         l_val  = 1'b0;
         r_left = $urandom_range(1, 200);
         l_left = $urandom_range(1, 200);
         for (int c = 0; c < 2500; c++) begin
            if (r_left == 0) begin
               r_val  = !r_val;
               r_left = r_val ? $urandom_range(1, 12) : $urandom_range(20, 150 + e * 150);
            end
            if (l_left == 0) begin
               l_val  = !l_val;
               l_left = l_val ? $urandom_range(1, 12) : $urandom_range(20, 150 + e * 150);
            end
            r_left--;
            l_left--;
            applyStimulus(r_val, l_val);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
